// File: rtl/amp_if_pkg.sv
// -----------------------------------------------------------------------------
// amp_if_pkg
//   Shared definitions for the Merus Gen1 amplifier control blocks.
//   - 3-bit state encodings of the startup sequencer (exposed on state_o)
//   - default timing constants, in system clock cycles
//   - packed bundle of the sequencer's registered outputs, plus the decode
//     from the state being entered to the output levels held in that state
// -----------------------------------------------------------------------------
package amp_if_pkg;

    localparam logic [2:0] ST_OFF       = 3'd0;
    localparam logic [2:0] ST_PWR_WAIT  = 3'd1;
    localparam logic [2:0] ST_CFG       = 3'd2;
    localparam logic [2:0] ST_CFG_WAIT  = 3'd3;
    localparam logic [2:0] ST_RUN       = 3'd4;
    localparam logic [2:0] ST_MUTE_WAIT = 3'd5;
    localparam logic [2:0] ST_FAULT     = 3'd6;

    localparam int T_PWR_DEF   = 1024;
    localparam int T_HOLD_DEF  = 32;
    localparam int T_CFG_DEF   = 4096;
    localparam int T_MUTE_DEF  = 256;
    localparam int T_RETRY_DEF = 65536;
    localparam int CNT_W_DEF   = 24;

    typedef struct packed {
        logic amp_en;
        logic amp_nmute;
        logic i2c_resetb;
        logic send_cfg;
        logic ready;
        logic fault;
    } amp_out_t;

    // Output levels are a pure function of the state being entered, so
    // registering this decode of the next state makes every output change
    // on the same edge as the transition that causes it.
    function automatic amp_out_t outs_for(input logic [2:0] st);
        amp_out_t o;
        o = '0;
        case (st)
            ST_PWR_WAIT, ST_CFG_WAIT, ST_MUTE_WAIT: begin
                o.amp_en     = 1'b1;
                o.i2c_resetb = 1'b1;
            end
            ST_CFG: begin
                o.amp_en     = 1'b1;
                o.i2c_resetb = 1'b1;
                o.send_cfg   = 1'b1;
            end
            ST_RUN: begin
                o.amp_en     = 1'b1;
                o.i2c_resetb = 1'b1;
                o.amp_nmute  = 1'b1;
                o.ready      = 1'b1;
            end
            ST_FAULT: o.fault = 1'b1;
            default:  o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Generic two-flop synchronizer for a single asynchronous level.
//   RST_VAL selects the value both flops take during reset, so an inactive
//   level (e.g. high for an active-low pin) is presented until real samples
//   have propagated through.
//   Ports:
//     clk   - destination clock
//     rst_n - asynchronous active-low reset
//     d     - asynchronous input
//     q     - synchronized output (2 clk edges of latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/amp_startup_seq.sv
// -----------------------------------------------------------------------------
// amp_startup_seq
//   Power-up / power-down sequencer for the Merus Gen1 amplifier. Enables the
//   amp, releases and triggers the I2C configuration master, waits for the
//   boot configuration transfer, then unmutes. Handles orderly shutdown
//   (mute, wait, disable) and fault hold-off/recovery.
//   Ports:
//     clk_in     - system clock (undivided)
//     resetb     - asynchronous active-low reset
//     start      - level request to run the amp
//     nfault     - amp fault pin, active low, asynchronous
//     amp_en     - amp power enable
//     amp_nmute  - amp mute control, 0 = muted
//     i2c_resetb - I2C master reset, low holds it in init
//     send_cfg   - configuration trigger to the I2C master
//     ready      - amp configured and unmuted
//     fault      - fault hold-off in progress
//     state_o    - current state encoding (debug)
// -----------------------------------------------------------------------------
module amp_startup_seq
    import amp_if_pkg::*;
#(
    parameter int T_PWR   = T_PWR_DEF,
    parameter int T_HOLD  = T_HOLD_DEF,
    parameter int T_CFG   = T_CFG_DEF,
    parameter int T_MUTE  = T_MUTE_DEF,
    parameter int T_RETRY = T_RETRY_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic       clk_in,
    input  logic       resetb,
    input  logic       start,
    input  logic       nfault,
    output logic       amp_en,
    output logic       amp_nmute,
    output logic       i2c_resetb,
    output logic       send_cfg,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);

    logic             nfault_s;
    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    amp_out_t         out_q, out_d;
    logic             expired;

    sync2 #(.RST_VAL(1'b1)) u_nfault_sync (
        .clk   (clk_in),
        .rst_n (resetb),
        .d     (nfault),
        .q     (nfault_s)
    );

    // Counter value loaded when a state is entered; untimed states load 0.
    function automatic logic [CNT_W-1:0] load_for(input logic [2:0] st);
        case (st)
            ST_PWR_WAIT:  return CNT_W'(T_PWR - 1);
            ST_CFG:       return CNT_W'(T_HOLD - 1);
            ST_CFG_WAIT:  return CNT_W'(T_CFG - 1);
            ST_MUTE_WAIT: return CNT_W'(T_MUTE - 1);
            ST_FAULT:     return CNT_W'(T_RETRY - 1);
            default:      return '0;
        endcase
    endfunction

    assign expired = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF: begin
                if (start) state_d = ST_PWR_WAIT;
            end
            // nfault is ignored while the amp boots: it may pull it low.
            ST_PWR_WAIT: begin
                if (!start)       state_d = ST_OFF;
                else if (expired) state_d = ST_CFG;
            end
            ST_CFG: begin
                if (!start)       state_d = ST_OFF;
                else if (expired) state_d = ST_CFG_WAIT;
            end
            ST_CFG_WAIT: begin
                if (!nfault_s)    state_d = ST_FAULT;
                else if (!start)  state_d = ST_OFF;
                else if (expired) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!nfault_s)    state_d = ST_FAULT;
                else if (!start)  state_d = ST_MUTE_WAIT;
            end
            // Shutdown always completes; a renewed start restarts from OFF
            // so the I2C master gets pulsed through reset again.
            ST_MUTE_WAIT: begin
                if (!nfault_s)    state_d = ST_FAULT;
                else if (expired) state_d = ST_OFF;
            end
            ST_FAULT: begin
                if (expired && nfault_s) state_d = ST_OFF;
            end
            default: state_d = ST_OFF;
        endcase

        if (state_d != state_q) cnt_d = load_for(state_d);
        else if (expired)       cnt_d = '0;
        else                    cnt_d = cnt_q - CNT_W'(1);

        out_d = outs_for(state_d);
    end

    always_ff @(posedge clk_in or negedge resetb) begin
        if (!resetb) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign amp_en     = out_q.amp_en;
    assign amp_nmute  = out_q.amp_nmute;
    assign i2c_resetb = out_q.i2c_resetb;
    assign send_cfg   = out_q.send_cfg;
    assign ready      = out_q.ready;
    assign fault      = out_q.fault;
    assign state_o    = state_q;

endmodule
